// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: sends a burst of square-wave periods on blinky at the
// frequency selected by cmd (1..4), then holds a quiet gap before reporting done.
// Latency: accept -> blinky high on the next cycle; all outputs registered.
// Backpressure: none; start is only sampled while idle, start while busy is dropped.
//
// Ports:
//   clock      - system clock, all logic on posedge
//   reset      - synchronous active-high reset, highest priority
//   cmd        - code to send (1=200 Hz, 2=1 kHz, 3=5 kHz, 4=7 kHz; others invalid)
//   start      - burst request, sampled only in IDLE
//   abort      - cancel the current burst (no done pulse)
//   blinky     - IR LED drive
//   busy       - high from accept until the end of the gap
//   done       - one-cycle pulse on normal completion
//   err        - one-cycle pulse when start arrives with an invalid cmd
//   active_cmd - latched code being sent, 0 when idle
module ir_beacon_tx #(
  parameter int HALF_200      = 250000,
  parameter int HALF_1000     = 50000,
  parameter int HALF_5000     = 10000,
  parameter int HALF_7000     = 7143,
  parameter int CNT_W         = 18,
  parameter int BURST_PERIODS = 32,
  parameter int GAP_CYCLES    = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] cmd,
  input  logic       start,
  input  logic       abort,
  output logic       blinky,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] active_cmd
);

  localparam int PER_W = (BURST_PERIODS > 1) ? $clog2(BURST_PERIODS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       act_q, act_d;
  logic             blinky_q, blinky_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Half-period reload value (HALF_sel - 1) for a given code.
  function automatic logic [CNT_W-1:0] half_reload(input logic [2:0] c);
    logic [CNT_W-1:0] r;
    case (c)
      3'd1:    r = CNT_W'(HALF_200 - 1);
      3'd2:    r = CNT_W'(HALF_1000 - 1);
      3'd3:    r = CNT_W'(HALF_5000 - 1);
      3'd4:    r = CNT_W'(HALF_7000 - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    per_d   = per_q;
    gap_d   = gap_q;
    act_d   = act_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd >= 3'd1 && cmd <= 3'd4) begin
            state_d = HIGH;
            half_d  = half_reload(cmd);
            per_d   = PER_W'(BURST_PERIODS - 1);
            act_d   = cmd;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (half_q == '0) begin
          state_d = LOW;
          half_d  = half_reload(act_q);
        end else begin
          half_d = half_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (half_q == '0) begin
          if (per_q != '0) begin
            per_d   = per_q - PER_W'(1);
            state_d = HIGH;
            half_d  = half_reload(act_q);
          end else begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
          end
        end else begin
          half_d = half_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          act_d   = 3'd0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever transition was computed above, including completion.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      act_d   = 3'd0;
      done_d  = 1'b0;
      half_d  = '0;
      per_d   = '0;
      gap_d   = '0;
    end

    blinky_d = (state_d == HIGH);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      half_q   <= '0;
      per_q    <= '0;
      gap_q    <= '0;
      act_q    <= 3'd0;
      blinky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      per_q    <= per_d;
      gap_q    <= gap_d;
      act_q    <= act_d;
      blinky_q <= blinky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign blinky     = blinky_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign active_cmd = act_q;

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Bench for ir_beacon_tx: directed scenarios plus random traffic; expected
// outputs come from a time-offset model of the burst and are checked by a
// monitor that pops one expected record per clock.
module tb_ir_beacon_tx;

  localparam int H200 = 8;
  localparam int H1K  = 4;
  localparam int H5K  = 2;
  localparam int H7K  = 1;
  localparam int BP   = 3;
  localparam int GAPC = 5;

  logic       clock = 1'b0;
  logic       reset, start, abort;
  logic [2:0] cmd;
  logic       blinky, busy, done, err;
  logic [2:0] active_cmd;

  always #5 clock = ~clock;

  ir_beacon_tx #(
    .HALF_200(H200), .HALF_1000(H1K), .HALF_5000(H5K), .HALF_7000(H7K),
    .CNT_W(4), .BURST_PERIODS(BP), .GAP_CYCLES(GAPC)
  ) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .start(start), .abort(abort),
    .blinky(blinky), .busy(busy), .done(done), .err(err), .active_cmd(active_cmd)
  );

  // Expected record: {blinky, busy, done, err, active_cmd}
  logic [6:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Model: code being sent (0 = idle) and cycles elapsed since the first high cycle.
  int   m_cmd = 0;
  int   m_t   = 0;
  logic m_done = 1'b0;

  function automatic int half_of(input int c);
    case (c)
      1: return H200;
      2: return H1K;
      3: return H5K;
      default: return H7K;
    endcase
  endfunction

  task automatic step_model(input logic r, input logic s, input logic [2:0] c,
                            input logic a, output logic [6:0] e);
    logic b, bz, d, er;
    logic [2:0] ac;
    int h;
    b = 1'b0; bz = 1'b0; d = 1'b0; er = 1'b0; ac = 3'd0;
    if (r) begin
      m_cmd = 0;
    end else if (m_cmd != 0) begin
      if (a) begin
        m_cmd = 0;
      end else begin
        m_t++;
        if (m_t == 2 * half_of(m_cmd) * BP + GAPC) begin
          m_cmd = 0;
          d = 1'b1;
        end
      end
    end else if (s) begin
      if (c >= 3'd1 && c <= 3'd4) begin
        m_cmd = int'(c);
        m_t   = 0;
      end else begin
        er = 1'b1;
      end
    end
    if (m_cmd != 0) begin
      h  = half_of(m_cmd);
      bz = 1'b1;
      ac = 3'(m_cmd);
      b  = (m_t < 2 * h * BP) && (((m_t / h) % 2) == 0);
    end
    m_done = d;
    e = {b, bz, d, er, ac};
  endtask

  // Drive one cycle of inputs (sampled at the following posedge) and queue the result.
  task automatic cyc(input logic r, input logic s, input logic [2:0] c, input logic a);
    logic [6:0] e;
    @(negedge clock);
    reset = r; start = s; cmd = c; abort = a;
    step_model(r, s, c, a, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [2:0] c);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, c, 1'b0);
  endtask

  // Monitor: one output record per clock, compared away from the edge.
  initial begin
    logic [6:0] e, got;
    forever begin
      @(posedge clock);
      #1;
      cyc_n++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {blinky, busy, done, err, active_cmd};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got blinky=%b busy=%b done=%b err=%b active_cmd=%0d, want blinky=%b busy=%b done=%b err=%b active_cmd=%0d",
                   cyc_n, got[6], got[5], got[4], got[3], got[2:0],
                   e[6], e[5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; cmd = 3'd0;

    // Reset state
    cyc(1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 3'd2, 1'b1);

    // 1: cmd=2 burst, then quiet
    cyc(1'b0, 1'b1, 3'd2, 1'b0);
    idle(34, 3'd2);

    // 2: cmd=4 burst, then cmd=1 with cmd changed and a stray start mid-burst
    cyc(1'b0, 1'b1, 3'd4, 1'b0);
    idle(14, 3'd0);
    cyc(1'b0, 1'b1, 3'd1, 1'b0);
    idle(5, 3'd1);
    idle(5, 3'd3);
    cyc(1'b0, 1'b1, 3'd3, 1'b0);
    idle(50, 3'd3);

    // 3: invalid commands
    cyc(1'b0, 1'b1, 3'd0, 1'b0);
    idle(2, 3'd0);
    cyc(1'b0, 1'b1, 3'd6, 1'b0);
    idle(2, 3'd0);

    // 4: start on the done cycle, with ignored starts while busy
    cyc(1'b0, 1'b1, 3'd3, 1'b0);
    cyc(1'b0, 1'b1, 3'd1, 1'b0);
    idle(3, 3'd0);
    cyc(1'b0, 1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 100 && !m_done; i++) cyc(1'b0, 1'b0, 3'd0, 1'b0);
    checks++;
    if (!m_done) begin
      errors++;
      $display("FAIL done_wait: burst did not complete within 100 cycles, required completion");
    end
    cyc(1'b0, 1'b1, 3'd3, 1'b0);
    idle(22, 3'd0);

    // 5: abort in the second HIGH phase of a cmd=1 burst, then a normal burst
    cyc(1'b0, 1'b1, 3'd1, 1'b0);
    idle(18, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 1'b1);
    idle(3, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 1'b1, 3'd2, 1'b0);
    idle(32, 3'd0);

    // 6: reset during GAP and during HIGH
    cyc(1'b0, 1'b1, 3'd2, 1'b0);
    idle(25, 3'd0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0);
    idle(3, 3'd0);
    cyc(1'b0, 1'b1, 3'd1, 1'b0);
    idle(2, 3'd0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0);
    idle(3, 3'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic r, s, a;
      logic [2:0] c;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 59) == 0);
      c = 3'($urandom_range(0, 7));
      cyc(r, s, c, a);
    end
    idle(2, 3'd0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_beacon_tx.md
Name: ir_beacon_tx

Overview:
IR beacon transmitter: the transmitting end of the blinky frequency link whose receiver classifies 200 / 1000 / 5000 / 7000 Hz square waves into codes 1-4.
- Takes a 3-bit command code plus a start strobe.
- Emits a square wave on blinky at the matching frequency for a fixed number of periods, then holds a quiet gap so the receiver's consecutive-decision counters clear.
- Sits in the controller/beacon board; drives the IR LED driver directly.

Parameters:
HALF_200, 250000, clock cycles per half-period for code 1 (200 Hz at 100 MHz)
HALF_1000, 50000, half-period cycles for code 2 (1000 Hz)
HALF_5000, 10000, half-period cycles for code 3 (5000 Hz)
HALF_7000, 7143, half-period cycles for code 4 (7000 Hz, rounded)
CNT_W, 18, half-period counter width; must hold max HALF_* minus 1
BURST_PERIODS, 32, full periods per burst (>=1)
GAP_CYCLES, 1000000, quiet cycles after burst (>=1; 10 ms at 100 MHz)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high
cmd  input  3  code to send: 1=200 Hz, 2=1000 Hz, 3=5000 Hz, 4=7000 Hz; 0 and 5-7 invalid
start  input  1  request; sampled only in IDLE
abort  input  1  cancel current burst
blinky  output  1  IR LED drive, registered
busy  output  1  high from accept until done
done  output  1  one-cycle pulse at normal completion
err  output  1  one-cycle pulse when start is given with an invalid cmd
active_cmd  output  3  latched code being sent; 0 when idle

Behaviour:
Reset (sync, active-high, highest priority, legal at any point):
- Next edge: state=IDLE; blinky=0, busy=0, done=0, err=0, active_cmd=0; counters cleared.

States:
- IDLE
- HIGH: blinky=1
- LOW: blinky=0
- GAP: blinky=0
All outputs registered. done and err default 0 every cycle unless set.

IDLE:
- start=1 with cmd in 1..4: next cycle state=HIGH, blinky=1, busy=1, active_cmd=cmd.
  - Half counter loaded with HALF_sel-1.
  - Period counter loaded with BURST_PERIODS-1.
  - cmd is ignored after accept.
- start=1 with invalid cmd: err=1 for one cycle; stays IDLE; busy stays 0.
- start=0: hold.

HIGH / LOW:
- Half counter decrements each cycle.
- At 0: state toggles and counter reloads with HALF_sel-1.
- Result: blinky is high exactly HALF_sel cycles, then low exactly HALF_sel cycles.
- LOW at 0:
  - period counter != 0: decrement it, go to HIGH.
  - period counter == 0: go to GAP, gap counter loaded with GAP_CYCLES-1.

GAP:
- blinky=0; gap counter decrements.
- At 0: next cycle state=IDLE, busy=0, done=1, active_cmd=0.
- start in that IDLE cycle (done high) is accepted normally: back-to-back bursts allowed.

abort=1 while busy (any non-IDLE state), no reset:
- Next cycle IDLE; blinky=0, busy=0, active_cmd=0; no done.
- abort in IDLE has no effect. abort wins over a same-cycle state transition.

Other rules:
- start while busy: ignored, no err.
- Total burst length from the first blinky high to done = 2*HALF_sel*BURST_PERIODS + GAP_CYCLES cycles.

Test Plan:
(Bench overrides: HALF_200=8, HALF_1000=4, HALF_5000=2, HALF_7000=1, BURST_PERIODS=3, GAP_CYCLES=5.)
1. Reset, then start=1, cmd=2 for one cycle -> blinky pattern 1111 0000 ×3, then 0 for 5 cycles. busy high 29 cycles. done pulses exactly once on cycle 30 after accept. active_cmd=2 while busy, 0 after.
2. cmd=4 burst -> blinky 101010 followed by gap. Then cmd=1 -> each high and low phase lasts 8 cycles. Changing cmd to 3 mid-burst does not alter the waveform or active_cmd.
3. start with cmd=0, then cmd=6 -> err pulses one cycle each. busy=0, blinky=0, done never asserts.
4. start asserted on the done cycle with cmd=3 -> new burst begins next cycle (blinky=1, busy=1) with no idle gap. start pulses during busy are ignored.
5. abort during second HIGH phase of a cmd=1 burst -> next cycle blinky=0, busy=0, active_cmd=0, no done. A following start works normally.
6. reset asserted during GAP and during HIGH -> next cycle all outputs 0, state IDLE. No done or err is emitted.
